muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand width; HI/LO are each WIDTH bits.
REQ-002 Port clock, input, 1: single clock; all state updates on rising edge.
REQ-003 Port reset, input, 1: asynchronous, active-high reset.
REQ-004 Port Stall, input, 1: EX stage stalled; no new operation accepted.
REQ-005 Port Flush, input, 1: EX stage flushed; blocks acceptance and aborts an in-flight divide.
REQ-006 Port Operation, input, 4: MulDiv opcode, encoded per the shared package.
REQ-007 Port A, input, WIDTH: rs operand; dividend or multiplicand.
REQ-008 Port B, input, WIDTH: rt operand; divisor or multiplier.
REQ-009 Port HI, output, WIDTH: HI register, driven directly from the register.
REQ-010 Port LO, output, WIDTH: LO register, driven directly from the register.
REQ-011 Port Busy, output, 1: divide in progress; the pipeline stalls mfhi/mflo and further MulDiv ops on it.
REQ-012 Port Done, output, 1: one-cycle pulse in the cycle after a divide writes HI/LO.

Function
REQ-013 Acceptance: Operation is not Nop, and Stall=0, Flush=0, Busy=0 at the edge; otherwise the op is ignored.
REQ-014 Mult/Multu: {HI,LO} is the full 2*WIDTH signed/unsigned product at the accepting edge (latency 1, Busy stays 0).
REQ-015 Mthi: HI<=A, LO unchanged. Mtlo: LO<=B, HI unchanged. Both latency 1.
REQ-016 Div/Divu: FSM IDLE -> DIV (WIDTH cycles, radix-2 restoring, one quotient bit per cycle) -> FIXUP (1 cycle) -> IDLE.
REQ-017 Busy=1 from the accepting edge through the FIXUP cycle: WIDTH+1 cycles.
REQ-018 HI/LO are written at the FIXUP-exit edge; Done=1 in the following cycle.
REQ-019 Signed divide: divide magnitudes; quotient truncates toward zero; remainder takes the sign of the dividend; sign fixup in FIXUP.
REQ-020 Divide operands are captured at acceptance; later changes to A/B have no effect.
REQ-021 Divisor zero: FSM still runs the full WIDTH+1 cycles; HI/LO are unchanged; Done pulses.
REQ-022 Most-negative / -1 signed: LO = most-negative value, HI = 0, no exception.
REQ-023 Flush=1 while Busy: next state IDLE, Busy=0 next cycle, HI/LO unchanged, no Done.
REQ-024 Stall during a divide does not pause the iteration.
REQ-025 The unit never raises overflow; no exception output exists.

Reset
REQ-026 Reset asserted: HI=0, LO=0, Busy=0, Done=0, FSM=IDLE, immediately and asynchronously.
REQ-027 Reset during a divide discards it; there is no Done.

Configuration
REQ-028 With MULDIV_MADD_EN defined, Madd/Maddu/Msub/Msubu are accepted with latency 1: {HI,LO} <= {HI,LO} +/- the signed/unsigned product, modulo 2^(2*WIDTH).
REQ-029 With MULDIV_MADD_EN undefined, those four opcodes are treated as Nop and no accumulate adder is synthesised.

Structure
REQ-030 Package muldiv_pkg holds the Operation encodings (Nop, Mult, Multu, Div, Divu, Mthi, Mtlo, Madd, Maddu, Msub, Msubu) and the FSM state encoding.
REQ-031 The iterative divider is a sub-module, div_iter, containing the FSM, the remainder/quotient shift registers and the iteration counter; muldiv_unit owns HI/LO.

Verification
REQ-032 WIDTH=32, Divu A=100 B=7 -> Busy for 33 cycles, then LO=14, HI=2, Done pulse.
REQ-033 Div A=0xFFFFFFF9 (-7) B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-034 Mult A=0xFFFFFFFF B=2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE; Multu with the same operands -> HI=1, LO=0xFFFFFFFE, Busy never set.
REQ-035 Div 100/7 with Flush asserted on iteration 10 -> Busy=0 the next cycle, HI/LO keep their prior values, no Done; Divu B=0 -> HI/LO unchanged, Done after 33 cycles.
REQ-036 MULDIV_MADD_EN defined, HI:LO=0:5, Madd A=3 B=4 -> LO=17; Msubu A=B=1 -> LO=16; Mult issued while Busy -> ignored.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the MulDiv unit: the opcodes on Operation and the divider FSM states.
package muldiv_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MADD  = 4'd7,
        OP_MADDU = 4'd8,
        OP_MSUB  = 4'd9,
        OP_MSUBU = 4'd10
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DIV   = 2'd1,
        S_FIXUP = 2'd2
    } div_state_e;

endpackage

// File: rtl/muldiv_unit_if.sv
// EX-stage <-> MulDiv unit bundle; the pipeline is the master, the unit is the slave.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    import muldiv_pkg::*;

    logic             Stall;
    logic             Flush;
    op_e              Operation;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic             Busy;
    logic             Done;

    modport master (output Stall, Flush, Operation, A, B,
                    input  HI, LO, Busy, Done);

    modport slave  (input  Stall, Flush, Operation, A, B,
                    output HI, LO, Busy, Done);

endinterface

// File: rtl/muldiv_unit_div_iter.sv
// Radix-2 restoring divider: WIDTH iteration cycles on magnitudes, then one sign-fixup cycle.
module div_iter
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_signed,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_finish,
    output logic             o_write,
    output logic [WIDTH-1:0] o_quot,
    output logic [WIDTH-1:0] o_rem
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    div_state_e       r_state;
    div_state_e       w_state_next;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_divisor;
    logic [CNT_W-1:0] r_count;
    logic             r_neg_quot;
    logic             r_neg_rem;
    logic             r_div_zero;
    logic [WIDTH:0]   w_trial;
    logic             w_last;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;

    assign w_last  = (r_count == CNT_W'(WIDTH - 1));
    assign w_a_mag = (i_signed && i_dividend[WIDTH-1]) ? -i_dividend : i_dividend;
    assign w_b_mag = (i_signed && i_divisor[WIDTH-1])  ? -i_divisor  : i_divisor;
    // A set top bit means the shifted remainder is smaller than the divisor: restore.
    assign w_trial = {r_rem, r_quot[WIDTH-1]} - {1'b0, r_divisor};

    // NOTE: async reset clears only control and datapath flops; nothing here is a RAM.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // NOTE: every output of this block is given a default first so no path infers a latch.
    always_comb begin
        w_state_next = r_state;
        o_busy       = 1'b0;
        o_finish     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_state_next = S_DIV;
            end
            S_DIV: begin
                o_busy = 1'b1;
                if (i_flush)     w_state_next = S_IDLE;
                else if (w_last) w_state_next = S_FIXUP;
            end
            S_FIXUP: begin
                o_busy       = 1'b1;
                o_finish     = !i_flush;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign o_write = o_finish && !r_div_zero;
    assign o_quot  = r_neg_quot ? -r_quot : r_quot;
    assign o_rem   = r_neg_rem  ? -r_rem  : r_rem;

    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rem      <= '0;
            r_quot     <= '0;
            r_divisor  <= '0;
            r_count    <= '0;
            r_neg_quot <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div_zero <= 1'b0;
        end else if (r_state == S_IDLE && i_start) begin
            r_rem      <= '0;
            r_quot     <= w_a_mag;
            r_divisor  <= w_b_mag;
            r_count    <= '0;
            r_neg_quot <= i_signed && (i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1]);
            r_neg_rem  <= i_signed && i_dividend[WIDTH-1];
            r_div_zero <= (i_divisor == '0);
        end else if (r_state == S_DIV) begin
            r_count <= r_count + CNT_W'(1);
            r_quot  <= {r_quot[WIDTH-2:0], ~w_trial[WIDTH]};
            if (!w_trial[WIDTH]) r_rem <= w_trial[WIDTH-1:0];
            else                 r_rem <= {r_rem[WIDTH-2:0], r_quot[WIDTH-1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// MulDiv unit owning HI/LO: single-cycle multiply/move, iterative divide via div_iter.
// Define MULDIV_MADD_EN to add the Madd/Maddu/Msub/Msubu accumulate opcodes.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          clock,
    input  logic          reset,
    muldiv_unit_if.slave  bus
);

    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic [WIDTH-1:0]   w_hi_next;
    logic [WIDTH-1:0]   w_lo_next;
    logic               w_accept;
    logic               w_start;
    logic               w_busy;
    logic               w_finish;
    logic               w_write;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [2*WIDTH-1:0] w_prod_u;

    assign w_accept = (bus.Operation != OP_NOP) && !bus.Stall && !bus.Flush && !w_busy;
    assign w_start  = w_accept && (bus.Operation == OP_DIV || bus.Operation == OP_DIVU);

    // Operands are extended to full width so the low 2*WIDTH bits are the exact product.
    assign w_prod_s = {{WIDTH{bus.A[WIDTH-1]}}, bus.A} * {{WIDTH{bus.B[WIDTH-1]}}, bus.B};
    assign w_prod_u = {{WIDTH{1'b0}}, bus.A} * {{WIDTH{1'b0}}, bus.B};

`ifdef MULDIV_MADD_EN
    logic [2*WIDTH-1:0] w_acc_prod;
    logic [2*WIDTH-1:0] w_acc_next;

    assign w_acc_prod = (bus.Operation == OP_MADD || bus.Operation == OP_MSUB) ? w_prod_s : w_prod_u;
    assign w_acc_next = (bus.Operation == OP_MSUB || bus.Operation == OP_MSUBU)
                      ? {r_hi, r_lo} - w_acc_prod
                      : {r_hi, r_lo} + w_acc_prod;
`endif

    div_iter #(.WIDTH(WIDTH)) u_div_iter (
        .clock      (clock),
        .reset      (reset),
        .i_start    (w_start),
        .i_signed   (bus.Operation == OP_DIV),
        .i_flush    (bus.Flush),
        .i_dividend (bus.A),
        .i_divisor  (bus.B),
        .o_busy     (w_busy),
        .o_finish   (w_finish),
        .o_write    (w_write),
        .o_quot     (w_quot),
        .o_rem      (w_rem)
    );

    // A divide write and an accepted op never coincide: nothing is accepted while busy.
    always_comb begin
        w_hi_next = r_hi;
        w_lo_next = r_lo;
        if (w_write) begin
            w_hi_next = w_rem;
            w_lo_next = w_quot;
        end else if (w_accept) begin
            case (bus.Operation)
                OP_MULT:  {w_hi_next, w_lo_next} = w_prod_s;
                OP_MULTU: {w_hi_next, w_lo_next} = w_prod_u;
                OP_MTHI:  w_hi_next = bus.A;
                OP_MTLO:  w_lo_next = bus.B;
`ifdef MULDIV_MADD_EN
                OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: {w_hi_next, w_lo_next} = w_acc_next;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
        end else begin
            r_hi   <= w_hi_next;
            r_lo   <= w_lo_next;
            r_done <= w_finish;
        end
    end

    assign bus.HI   = r_hi;
    assign bus.LO   = r_lo;
    assign bus.Busy = w_busy;
    assign bus.Done = r_done;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table for single ops and divides, plus flush/stall/reset sequences.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    typedef struct {
        op_e          op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    logic clock = 1'b0;
    logic reset;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clock = ~clock;

    muldiv_unit_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic issue(input op_e op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clock);
        bus.Operation = op;
        bus.A         = a;
        bus.B         = b;
        @(posedge clock);
        #1;
        bus.Operation = OP_NOP;
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        while (bus.Busy && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[16];
        int   n;
        logic seen_done;
        logic seen_busy;
        logic is_div;

        vecs[0]  = '{OP_MULT,  32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE};
        vecs[2]  = '{OP_MTHI,  32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFE};
        vecs[3]  = '{OP_MTLO,  32'd0,        32'h9ABCDEF0, 32'h12345678, 32'h9ABCDEF0};
        vecs[4]  = '{OP_NOP,   32'd1,        32'd1,        32'h12345678, 32'h9ABCDEF0};
        vecs[5]  = '{OP_MULT,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[6]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[7]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[8]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
        vecs[9]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[10] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
        vecs[11] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
        vecs[12] = '{OP_DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF};
        vecs[13] = '{OP_DIVU,  32'd5,        32'd9,        32'd5,        32'd0};
        vecs[14] = '{OP_DIV,   32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFF2};
        vecs[15] = '{OP_DIVU,  32'h80000000, 32'd3,        32'd2,        32'h2AAAAAAA};

        reset         = 1'b1;
        bus.Stall     = 1'b0;
        bus.Flush     = 1'b0;
        bus.Operation = OP_NOP;
        bus.A         = '0;
        bus.B         = '0;
        #12;
        check("reset_hi",   bus.HI,   0);
        check("reset_lo",   bus.LO,   0);
        check("reset_busy", bus.Busy, 0);
        check("reset_done", bus.Done, 0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            is_div = (vecs[i].op == OP_DIV) || (vecs[i].op == OP_DIVU);
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            if (is_div) begin
                check($sformatf("vec%0d_busy_set", i), bus.Busy, 1);
                wait_busy(n);
                check($sformatf("vec%0d_busy_cycles", i), n, 33);
                check($sformatf("vec%0d_done", i), bus.Done, 1);
            end else begin
                check($sformatf("vec%0d_busy", i), bus.Busy, 0);
                check($sformatf("vec%0d_done", i), bus.Done, 0);
            end
            check($sformatf("vec%0d_hi", i), bus.HI, vecs[i].hi);
            check($sformatf("vec%0d_lo", i), bus.LO, vecs[i].lo);
            if (is_div) begin
                tick(1);
                check($sformatf("vec%0d_done_clear", i), bus.Done, 0);
            end
        end

        // Operands change, Stall held and a Mult offered mid-divide: none may disturb it.
        issue(OP_DIVU, 32'd100, 32'd7);
        @(negedge clock);
        bus.A         = 32'd999;
        bus.B         = 32'd3;
        bus.Operation = OP_MULT;
        bus.Stall     = 1'b1;
        n = 0;
        while (bus.Busy && n < 100) begin
            @(posedge clock);
            #1;
            n++;
            if (n == 10) bus.Stall = 1'b0;
        end
        bus.Operation = OP_NOP;
        check("capture_busy_cycles", n, 33);
        check("capture_done", bus.Done, 1);
        check("capture_hi", bus.HI, 32'd2);
        check("capture_lo", bus.LO, 32'd14);

        // Flush on iteration 10 aborts the divide.
        issue(OP_MTHI, 32'hAAAA0001, 32'd0);
        issue(OP_MTLO, 32'd0, 32'h55550002);
        issue(OP_DIV, 32'd100, 32'd7);
        tick(9);
        @(negedge clock);
        bus.Flush     = 1'b1;
        bus.Operation = OP_MULT;
        bus.A         = 32'd5;
        bus.B         = 32'd5;
        @(posedge clock);
        #1;
        bus.Flush     = 1'b0;
        bus.Operation = OP_NOP;
        check("flush_busy_clear", bus.Busy, 0);
        seen_done = 1'b0;
        repeat (40) begin
            tick(1);
            if (bus.Done) seen_done = 1'b1;
        end
        check("flush_no_done", seen_done, 0);
        check("flush_hi", bus.HI, 32'hAAAA0001);
        check("flush_lo", bus.LO, 32'h55550002);

        // Flush or Stall while idle blocks acceptance.
        @(negedge clock);
        bus.Flush     = 1'b1;
        bus.Operation = OP_MTHI;
        bus.A         = 32'd1;
        @(posedge clock);
        #1;
        bus.Flush = 1'b0;
        bus.Stall = 1'b1;
        @(posedge clock);
        #1;
        bus.Stall     = 1'b0;
        bus.Operation = OP_NOP;
        check("blocked_hi", bus.HI, 32'hAAAA0001);

        // Divide by zero runs the full length, pulses Done, leaves HI/LO alone.
        issue(OP_DIVU, 32'd5, 32'd0);
        wait_busy(n);
        check("divzero_busy_cycles", n, 33);
        check("divzero_done", bus.Done, 1);
        check("divzero_hi", bus.HI, 32'hAAAA0001);
        check("divzero_lo", bus.LO, 32'h55550002);

        // Reset mid-divide clears state at once and discards the divide.
        issue(OP_DIVU, 32'd100, 32'd7);
        tick(5);
        #2;
        reset = 1'b1;
        #1;
        check("rstdiv_hi",   bus.HI,   0);
        check("rstdiv_lo",   bus.LO,   0);
        check("rstdiv_busy", bus.Busy, 0);
        @(negedge clock);
        reset = 1'b0;
        seen_done = 1'b0;
        seen_busy = 1'b0;
        repeat (40) begin
            tick(1);
            if (bus.Done) seen_done = 1'b1;
            if (bus.Busy) seen_busy = 1'b1;
        end
        check("rstdiv_no_done", seen_done, 0);
        check("rstdiv_no_busy", seen_busy, 0);

        // Accumulate opcodes: active only when the option is built in.
        issue(OP_MTHI, 32'd0, 32'd0);
        issue(OP_MTLO, 32'd0, 32'd5);
        issue(OP_MADD, 32'd3, 32'd4);
`ifdef MULDIV_MADD_EN
        check("madd_hilo", {bus.HI, bus.LO}, 64'd17);
        issue(OP_MSUBU, 32'd1, 32'd1);
        check("msubu_hilo", {bus.HI, bus.LO}, 64'd16);
        issue(OP_MADD, 32'hFFFFFFFF, 32'd1);
        check("madd_neg_hilo", {bus.HI, bus.LO}, 64'd15);
        issue(OP_MSUB, 32'd32, 32'd1);
        check("msub_wrap_hilo", {bus.HI, bus.LO}, 64'hFFFFFFFF_FFFFFFEF);
        issue(OP_MADDU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("maddu_wrap_hilo", {bus.HI, bus.LO}, 64'hFFFFFFFD_FFFFFFF0);
`else
        check("madd_nop_hilo", {bus.HI, bus.LO}, 64'd5);
        issue(OP_MSUBU, 32'd1, 32'd1);
        check("msubu_nop_hilo", {bus.HI, bus.LO}, 64'd5);
        issue(OP_MADDU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("maddu_nop_hilo", {bus.HI, bus.LO}, 64'd5);
`endif
        check("madd_busy", bus.Busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
